// File: rtl/act_quant_pkg.sv
// Shared types and constants for the activation quantiser (act_quant).
package act_quant_pkg;

    localparam int SHIFT_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Beat counter width; a one-beat frame still needs a 1-bit counter.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/act_quant_lane.sv
// One channel of act_quant: input capture, ReLU/round/shift stage, saturation stage.
// Rounding (round half up before the shift) is enabled by defining ACT_QUANT_ROUND_EN.
module act_quant_lane
    import act_quant_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_en,
    input  logic                         s1_en,
    input  logic                         s2_en,
    input  logic [SHIFT_W-1:0]           shift,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic [OUT_WIDTH-1:0]         dout
);

    // One extra bit so the rounding addend cannot overflow the largest positive input.
    localparam int EXT_W = DATA_WIDTH + 1;

    logic signed [DATA_WIDTH-1:0] din_r;
    logic [EXT_W-1:0]             relu_s;
    logic [EXT_W-1:0]             rnd_s;
    logic [EXT_W-1:0]             sum_s;
    logic [EXT_W-1:0]             shr_s;
    logic [EXT_W-1:0]             q1_r;
    logic [OUT_WIDTH-1:0]         dout_r;

    function automatic logic [OUT_WIDTH-1:0] saturate(input logic [EXT_W-1:0] v);
        if (|v[EXT_W-1:OUT_WIDTH]) begin
            return {OUT_WIDTH{1'b1}};
        end else begin
            return v[OUT_WIDTH-1:0];
        end
    endfunction

    // Input capture of the accepted beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            din_r <= {DATA_WIDTH{1'b0}};
        end else if (in_en) begin
            din_r <= din;
        end else begin
            din_r <= din_r;
        end
    end

    // ReLU, optional rounding addend and logical right shift.
    always_comb begin
        relu_s = {EXT_W{1'b0}};
        rnd_s  = {EXT_W{1'b0}};
        if (din_r[DATA_WIDTH-1]) begin
            relu_s = {EXT_W{1'b0}};
        end else begin
            relu_s = {1'b0, din_r};
        end
`ifdef ACT_QUANT_ROUND_EN
        if (shift != {SHIFT_W{1'b0}}) begin
            rnd_s = {{(EXT_W-1){1'b0}}, 1'b1} << (shift - SHIFT_W'(1));
        end else begin
            rnd_s = {EXT_W{1'b0}};
        end
`else
        rnd_s = {EXT_W{1'b0}};
`endif
        sum_s = relu_s + rnd_s;
        shr_s = sum_s >> shift;
    end

    // Stage 1 register: shifted magnitude.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q1_r <= {EXT_W{1'b0}};
        end else if (s1_en) begin
            q1_r <= shr_s;
        end else begin
            q1_r <= q1_r;
        end
    end

    // Stage 2 register: saturated output, held between valid beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_r <= {OUT_WIDTH{1'b0}};
        end else if (s2_en) begin
            dout_r <= saturate(q1_r);
        end else begin
            dout_r <= dout_r;
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/act_quant.sv
// Activation quantiser: per-channel ReLU -> shift -> saturate with frame tracking.
// Define ACT_QUANT_ROUND_EN to round half up before shifting instead of truncating.
module act_quant
    import act_quant_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int CHANNEL_NUM = 128,
    parameter int FM_DEPTH    = 64
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         data_in_valid,
    input  logic signed [DATA_WIDTH-1:0] data_in [CHANNEL_NUM],
    input  logic [SHIFT_W-1:0]           quant_shift,
    output logic                         data_out_valid,
    output logic [OUT_WIDTH-1:0]         data_out [CHANNEL_NUM],
    output logic                         frame_last,
    output logic                         busy
);

    localparam int                CNT_W    = cnt_width(FM_DEPTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FM_DEPTH - 1);

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;
    logic [SHIFT_W-1:0]   shift_r;
    logic [SHIFT_W-1:0]   shift_s;
    logic                 is_last_s;
    logic                 in_vld_r;
    logic                 in_last_r;
    logic                 s1_vld_r;
    logic                 s1_last_r;
    logic                 out_vld_r;
    logic                 out_last_r;

    // Frame FSM next state, beat counter and shift latch.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        shift_s   = shift_r;
        is_last_s = (cnt_r == LAST_CNT);
        case (state_r)
            IDLE: begin
                if (data_in_valid) begin
                    shift_s = quant_shift;
                    if (is_last_s) begin
                        state_s = IDLE;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = RUN;
                        cnt_s   = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (data_in_valid) begin
                    if (is_last_s) begin
                        state_s = IDLE;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = RUN;
                        cnt_s   = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {SHIFT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
        end
    end

    // Valid and frame-last markers travelling alongside the lane pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_vld_r   <= 1'b0;
            in_last_r  <= 1'b0;
            s1_vld_r   <= 1'b0;
            s1_last_r  <= 1'b0;
            out_vld_r  <= 1'b0;
            out_last_r <= 1'b0;
        end else begin
            in_vld_r   <= data_in_valid;
            in_last_r  <= data_in_valid & is_last_s;
            s1_vld_r   <= in_vld_r;
            s1_last_r  <= in_vld_r & in_last_r;
            out_vld_r  <= s1_vld_r;
            out_last_r <= s1_vld_r & s1_last_r;
        end
    end

    // The lanes' shift stage reads shift_r, which already holds the value latched with the frame's first beat.
    for (genvar ch = 0; ch < CHANNEL_NUM; ch++) begin : g_lane
        act_quant_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .OUT_WIDTH  (OUT_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rstn  (rstn),
            .in_en (data_in_valid),
            .s1_en (in_vld_r),
            .s2_en (s1_vld_r),
            .shift (shift_r),
            .din   (data_in[ch]),
            .dout  (data_out[ch])
        );
    end

    assign data_out_valid = out_vld_r;
    assign frame_last     = out_last_r;
    assign busy           = (state_r == RUN);

endmodule

// File: tb/tb_act_quant.sv
// Self-checking bench for act_quant: directed corner beats, frames, random traffic, mid-frame reset.
module tb_act_quant;

    localparam int DW = 16;
    localparam int OW = 8;
    localparam int CN = 128;
    localparam int FD = 64;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 data_in_valid;
    logic signed [DW-1:0] data_in [CN];
    logic [3:0]           quant_shift;
    logic                 data_out_valid;
    logic [OW-1:0]        data_out [CN];
    logic                 frame_last;
    logic                 busy;

    typedef struct packed {
        int            due;
        logic          last;
        logic [CN*OW-1:0] d;
    } exp_t;

    exp_t             exp_q[$];
    logic [CN*OW-1:0] hold_v;
    int               edge_cnt = 0;
    int               n_cmp = 0;
    int               n_err = 0;
    int               m_cnt = 0;
    int               m_shift = 0;

    act_quant dut (
        .clk            (clk),
        .rstn           (rstn),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .quant_shift    (quant_shift),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .frame_last     (frame_last),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: ReLU, optional round half up, shift, clamp to 8-bit unsigned.
    function automatic int ref_quant(input int x, input int s);
        int v;
        v = (x < 0) ? 0 : x;
`ifdef ACT_QUANT_ROUND_EN
        if (s > 0) v = v + (1 << (s - 1));
`endif
        v = v >> s;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < CN; i++) begin
            case ($urandom_range(0, 3))
                0: data_in[i] = DW'($urandom);
                1: data_in[i] = DW'($urandom_range(0, 4095));
                2: begin
                    case ($urandom_range(0, 3))
                        0: data_in[i] = 16'sh7FFF;
                        1: data_in[i] = 16'sh8000;
                        2: data_in[i] = 16'shFFFF;
                        default: data_in[i] = 16'sh0000;
                    endcase
                end
                default: data_in[i] = DW'($urandom_range(0, 511));
            endcase
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
            e = exp_q.pop_front();
            check("valid", 32'(data_out_valid), 32'd1);
            check("frame_last", 32'(frame_last), 32'(e.last));
            for (int i = 0; i < CN; i++) begin
                check("data", 32'(data_out[i]), 32'(e.d[i*OW +: OW]));
            end
            hold_v = e.d;
        end else begin
            check("valid_idle", 32'(data_out_valid), 32'd0);
            check("last_idle", 32'(frame_last), 32'd0);
            check("hold_ch0", 32'(data_out[0]), 32'(hold_v[0 +: OW]));
            check("hold_chN", 32'(data_out[CN-1]), 32'(hold_v[(CN-1)*OW +: OW]));
        end
        check("busy", 32'(busy), 32'(m_cnt != 0));
    endtask

    // Called at a negedge: present one cycle of input, advance the model, check after the edge.
    task automatic beat(input bit v, input logic [3:0] sh);
        exp_t e;
        data_in_valid = v;
        quant_shift   = sh;
        if (v) begin
            if (m_cnt == 0) m_shift = int'(sh);
            e.due  = edge_cnt + 3;
            e.last = (m_cnt == FD - 1);
            e.d    = '0;
            for (int i = 0; i < CN; i++) begin
                e.d[i*OW +: OW] = OW'(ref_quant(int'(data_in[i]), m_shift));
            end
            m_cnt = (m_cnt == FD - 1) ? 0 : m_cnt + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        data_in_valid = 1'b0;
        exp_q.delete();
        hold_v  = '0;
        m_cnt   = 0;
        m_shift = 0;
        #1;
        check("rst_valid", 32'(data_out_valid), 32'd0);
        check("rst_last", 32'(frame_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ch0", 32'(data_out[0]), 32'd0);
        check("rst_chN", 32'(data_out[CN-1]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn          = 1'b0;
        data_in_valid = 1'b0;
        quant_shift   = 4'd0;
        for (int i = 0; i < CN; i++) data_in[i] = 16'sh0000;
        @(negedge clk);
        do_reset();

        // Single beat with shift 2: 0x0100, negatives, saturation and the rounding case.
        rand_data();
        data_in[0] = 16'sh0100;
        data_in[1] = 16'sh8000;
        data_in[2] = 16'shFFFF;
        data_in[3] = 16'sh7FFF;
        data_in[4] = 16'sh0006;
        beat(1'b1, 4'd2);
        repeat (4) beat(1'b0, 4'd0);
        check("spec_0100", 32'(data_out[0]), 32'd64);
        check("spec_8000", 32'(data_out[1]), 32'd0);
        check("spec_ffff", 32'(data_out[2]), 32'd0);
`ifdef ACT_QUANT_ROUND_EN
        check("spec_six", 32'(data_out[4]), 32'd2);
`else
        check("spec_six", 32'(data_out[4]), 32'd1);
`endif

        // Largest positive input with no shift saturates.
        do_reset();
        rand_data();
        data_in[3] = 16'sh7FFF;
        beat(1'b1, 4'd0);
        repeat (4) beat(1'b0, 4'd0);
        check("spec_7fff", 32'(data_out[3]), 32'd255);

        // Full frame, shift request changes from 2 to 5 at beat 10.
        do_reset();
        for (int b = 0; b < FD; b++) begin
            rand_data();
            beat(1'b1, (b < 10) ? 4'd2 : 4'd5);
        end
        repeat (4) beat(1'b0, 4'd0);

        // Random traffic: gaps, back-to-back beats, several frames.
        for (int c = 0; c < 600; c++) begin
            rand_data();
            beat($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)));
        end
        repeat (4) beat(1'b0, 4'd0);

        // Reset at beat 20, then a fresh back-to-back frame.
        do_reset();
        for (int b = 0; b < 20; b++) begin
            rand_data();
            beat(1'b1, 4'd3);
        end
        do_reset();
        for (int b = 0; b < FD + 6; b++) begin
            rand_data();
            beat(1'b1, 4'($urandom_range(0, 15)));
        end
        repeat (5) beat(1'b0, 4'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
